wb_bus_arbiter: RTL and testbench
=================================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 The block SHALL have parameter: TIMEOUT, 8'd255, number of granted cycles without slave ack before a forced error ack.
REQ-002 The block SHALL have reset rst (synchronous, active-high) and clock clk: clk in 1 rising-edge clock; rst in 1 synchronous active-high reset.
REQ-003 Master ports SHALL be, per master k in {0 = instruction bus, 1 = data bus}:
- mk_addr_i in 32, address
- mk_data_i in 32, write data
- mk_we_i in 1, write enable
- mk_sel_i in 4, byte select
- mk_stb_i in 1, strobe
- mk_cyc_i in 1, cycle request
- mk_data_o out 32, read data
- mk_ack_o out 1, ack
REQ-004 Slave-side ports SHALL be:
- s_addr_o out 32, s_data_o out 32, s_we_o out 1, s_sel_o out 4, s_cyc_o out 1 (shared)
- s_stb_o out 4, one strobe per slave
- s0_data_i..s3_data_i in 32 each, slave read data
- s_ack_i in 4, per-slave ack
REQ-005 The block SHALL have timeout_o out 1: one-cycle pulse on a forced timeout ack.

Function
REQ-006 The FSM SHALL have states IDLE, BUSY0 (m0 granted) and BUSY1 (m1 granted).
REQ-007 Address decode at grant SHALL use addr[31:28]: 0x0..0x3 select slave 0..3; any other value is unmapped. The selection SHALL be registered as sel_q, with unmapped_q set for unmapped addresses.
REQ-008 In IDLE, a master requesting alone (mk_cyc_i=1) SHALL be granted at the next edge.
REQ-009 In IDLE, if both masters request, the master other than last_gnt SHALL be granted, and last_gnt SHALL update to the granted master.
REQ-010 Grant latency SHALL be exactly one cycle: a request first sampled at edge E gives s_stb_o active from edge E to E+1.
REQ-011 In BUSYk, s_addr_o, s_data_o, s_we_o and s_sel_o SHALL equal master k's inputs; s_cyc_o SHALL equal mk_cyc_i.
REQ-012 In BUSYk, s_stb_o[sel_q] SHALL equal mk_stb_i & mk_cyc_i & ~unmapped_q & ~tmo; all other s_stb_o bits SHALL be 0.
REQ-013 In IDLE, all slave-side outputs SHALL be 0.
REQ-014 In BUSYk, mk_ack_o SHALL equal s_ack_i[sel_q] (combinational) and mk_data_o SHALL equal s<sel_q>_data_i. The non-granted master's ack and data SHALL be 0.
REQ-015 Unmapped access: mk_ack_o=1 and mk_data_o=0 SHALL occur in the first BUSYk cycle; no s_stb_o SHALL assert.
REQ-016 Timeout counter cnt (8 bit) SHALL be cleared on grant and increment each BUSY cycle without ack. tmo SHALL be defined as cnt==TIMEOUT.
REQ-017 When tmo=1, mk_ack_o SHALL be 1, mk_data_o SHALL be 0, and timeout_o SHALL be 1 for that cycle.
REQ-018 On any ack to the granted master (slave, unmapped or timeout), the next state SHALL be IDLE.
REQ-019 Abort: if mk_cyc_i=0 in BUSYk without ack, s_stb_o SHALL be 0 in the same cycle and the next state SHALL be IDLE, with no ack.
REQ-020 Acks on s_ack_i from non-selected slaves, or arriving in IDLE, SHALL be ignored.
REQ-021 In IDLE, both mk_ack_o SHALL be 0.
REQ-022 A request arriving while the other master is busy SHALL wait; it SHALL be granted at the edge after the busy master returns to IDLE, at the earliest.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL set state=IDLE, last_gnt=1 (so m0 wins the first tie), cnt=0, sel_q=0, unmapped_q=0.
REQ-024 While rst=1, all outputs SHALL be 0.
REQ-025 A reset asserted mid-transaction SHALL drop s_stb_o and s_cyc_o to 0 in the cycle after the edge, and SHALL generate no ack.

Verification
REQ-026 Read scenario: m1 reads 0x1000_0004, and slave1 acks with 0x1234_5678 after 2 wait cycles -> s_stb_o=4'b0010 for 3 cycles; m1_ack_o=1 with m1_data_o=0x1234_5678 in the third cycle; m0_ack_o stays 0; IDLE next.
REQ-027 Arbitration scenario: after reset, m0 and m1 request simultaneously (both to slave0, 1-cycle ack) -> m0 served first, then m1. A further simultaneous request -> m0 served first again, since last_gnt=1 after m1.
REQ-028 Unmapped scenario: m0 reads 0x8000_0000 -> m0_ack_o=1 and m0_data_o=0 in the first granted cycle; s_stb_o=0 throughout.
REQ-029 Timeout scenario: TIMEOUT=4 and slave2 never acks -> s_stb_o[2]=1 for 4 cycles; fifth granted cycle has m1_ack_o=1, data 0, timeout_o=1, s_stb_o=0.
REQ-030 Abort scenario: m0 drops cyc in its second wait cycle while m1 is pending -> s_stb_o=0 that cycle; no m0 ack; m1 granted two edges later.
REQ-031 Reset scenario: rst asserted during a BUSY1 wait -> outputs 0 next cycle; a subsequent simultaneous request grants m0.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master, four-slave Wishbone arbiter.
// Master 0 is the instruction bus and master 1 is the data bus.
// Each grant lasts for one transaction. The slave is chosen by addr[31:28]
// at grant time. Addresses outside slaves 0..3 get an immediate error-free ack
// with zero data. A granted cycle that gets no ack for TIMEOUT cycles is
// ended with a forced ack and a timeout_o pulse.
module wb_bus_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (instruction bus)
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  // master 1 (data bus)
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  // slave side
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic [3:0]  s_stb_o,
  input  logic [31:0] s0_data_i,
  input  logic [31:0] s1_data_i,
  input  logic [31:0] s2_data_i,
  input  logic [31:0] s3_data_i,
  input  logic [3:0]  s_ack_i,
  output logic        timeout_o
);

  // state | meaning
  // IDLE  | no grant, all slave-side outputs low
  // BUSY0 | master 0 owns the bus until ack or abort
  // BUSY1 | master 1 owns the bus until ack or abort
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t      state_q;
  logic        last_gnt_q;
  logic [7:0]  cnt_q;
  logic [1:0]  sel_q;
  logic        unmapped_q;

  logic        gnt_d;
  logic        gnt_m1_d;
  logic [31:0] gnt_addr_d;
  logic [1:0]  sel_d;
  logic        unmapped_d;

  logic        busy;
  logic        own_m1;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        m_stb;
  logic        m_cyc;
  logic        tmo;
  logic        slv_ack;
  logic [31:0] slv_data;
  logic        ack;
  logic [31:0] rdata;
  logic [3:0]  stb;

  // Grant decision in IDLE: a lone requester wins; on a tie the master that
  // was not granted last time wins. The address is decoded from the winner.
  always_comb begin
    gnt_d    = m0_cyc_i | m1_cyc_i;
    gnt_m1_d = 1'b0;
    if (m0_cyc_i && m1_cyc_i) begin
      gnt_m1_d = ~last_gnt_q;
    end else if (m1_cyc_i) begin
      gnt_m1_d = 1'b1;
    end
    gnt_addr_d = gnt_m1_d ? m1_addr_i : m0_addr_i;
    sel_d      = gnt_addr_d[29:28];
    unmapped_d = (gnt_addr_d[31:30] != 2'b00);
  end

  // Mux the owning master onto the slave side and the selected slave back.
  always_comb begin
    busy     = (state_q != IDLE);
    own_m1   = (state_q == BUSY1);
    m_addr   = own_m1 ? m1_addr_i : m0_addr_i;
    m_wdata  = own_m1 ? m1_data_i : m0_data_i;
    m_we     = own_m1 ? m1_we_i   : m0_we_i;
    m_sel    = own_m1 ? m1_sel_i  : m0_sel_i;
    m_stb    = own_m1 ? m1_stb_i  : m0_stb_i;
    m_cyc    = own_m1 ? m1_cyc_i  : m0_cyc_i;
    tmo      = busy && (cnt_q == TIMEOUT);
    slv_ack  = s_ack_i[sel_q];
    case (sel_q)
      2'd0:    slv_data = s0_data_i;
      2'd1:    slv_data = s1_data_i;
      2'd2:    slv_data = s2_data_i;
      default: slv_data = s3_data_i;
    endcase
    // Unmapped and timed-out cycles return zero data so that a stale slave
    // bus never leaks into the master.
    ack      = busy & (tmo | unmapped_q | slv_ack);
    rdata    = (tmo | unmapped_q) ? 32'h0 : slv_data;
    stb      = 4'b0000;
    stb[sel_q] = busy & m_stb & m_cyc & ~unmapped_q & ~tmo;
  end

  // Drive the ports. Reset forces everything low combinationally so that the
  // bus is quiet for the whole reset cycle, not only after the edge.
  always_comb begin
    s_addr_o  = (busy && !rst) ? m_addr  : 32'h0;
    s_data_o  = (busy && !rst) ? m_wdata : 32'h0;
    s_we_o    = busy & ~rst & m_we;
    s_sel_o   = (busy && !rst) ? m_sel   : 4'h0;
    s_cyc_o   = busy & ~rst & m_cyc;
    s_stb_o   = rst ? 4'b0000 : stb;
    timeout_o = tmo & ~rst;
    m0_ack_o  = (state_q == BUSY0) & ~rst & ack;
    m1_ack_o  = (state_q == BUSY1) & ~rst & ack;
    m0_data_o = ((state_q == BUSY0) && !rst) ? rdata : 32'h0;
    m1_data_o = ((state_q == BUSY1) && !rst) ? rdata : 32'h0;
  end

  // Arbitration FSM with the watchdog counter and the latched slave select.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= 8'h0;
      sel_q      <= 2'd0;
      unmapped_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_d) begin
            state_q    <= gnt_m1_d ? BUSY1 : BUSY0;
            last_gnt_q <= gnt_m1_d;
            cnt_q      <= 8'h0;
            sel_q      <= sel_d;
            unmapped_q <= unmapped_d;
          end
        end
        BUSY0, BUSY1: begin
          if (ack || !m_cyc) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter, built with TIMEOUT=4 so the watchdog
// path is reachable in a few cycles. Inputs change 1 ns after a rising edge;
// outputs are checked 1 ns later, in the same cycle.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack;
  logic [31:0] s_addr, s_wdat;
  logic        s_we, s_cyc;
  logic [3:0]  s_sel, s_stb, s_ack;
  logic [31:0] s0_dat, s1_dat, s2_dat, s3_dat;
  logic        tmo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr), .m0_data_i(m0_wdat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_data_o(m0_rdat), .m0_ack_o(m0_ack),
    .m1_addr_i(m1_addr), .m1_data_i(m1_wdat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_data_o(m1_rdat), .m1_ack_o(m1_ack),
    .s_addr_o(s_addr), .s_data_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s0_data_i(s0_dat), .s1_data_i(s1_dat), .s2_data_i(s2_dat), .s3_data_i(s3_dat),
    .s_ack_i(s_ack), .timeout_o(tmo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    m0_addr = '0; m0_wdat = '0; m0_we = 0; m0_sel = 4'hf; m0_stb = 0; m0_cyc = 0;
    m1_addr = '0; m1_wdat = '0; m1_we = 0; m1_sel = 4'hf; m1_stb = 0; m1_cyc = 0;
    s_ack = 4'b0000;
  endtask

  task automatic req0(input logic [31:0] a);
    m0_addr = a; m0_stb = 1; m0_cyc = 1;
  endtask

  task automatic req1(input logic [31:0] a);
    m1_addr = a; m1_stb = 1; m1_cyc = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_in();
    s0_dat = 32'hA0A0_0000; s1_dat = 32'h1234_5678;
    s2_dat = 32'hC2C2_C2C2; s3_dat = 32'hD3D3_D3D3;

    // reset: outputs low even with requests and acks present
    step();
    req1(32'h1000_0000); s_ack = 4'b1111;
    settle();
    chk("rst_stb", {28'h0, s_stb}, 32'h0);
    chk("rst_cyc", {31'h0, s_cyc}, 32'h0);
    chk("rst_acks", {30'h0, m0_ack, m1_ack}, 32'h0);
    chk("rst_tmo", {31'h0, tmo}, 32'h0);
    step();
    clear_in();
    rst = 0;

    // IDLE ignores stray slave acks
    s_ack = 4'b1111;
    settle();
    chk("idle_ack_ign", {30'h0, m0_ack, m1_ack}, 32'h0);
    chk("idle_addr", s_addr, 32'h0);

    // read: m1 to slave1, acked after 2 wait cycles
    s_ack = 4'b0000;
    req1(32'h1000_0004);
    settle();
    chk("rd_idle_stb", {28'h0, s_stb}, 32'h0);
    step();
    settle();
    chk("rd_w1_stb", {28'h0, s_stb}, 32'h2);
    chk("rd_w1_addr", s_addr, 32'h1000_0004);
    chk("rd_w1_ack", {31'h0, m1_ack}, 32'h0);
    step();
    s_ack = 4'b0001;
    settle();
    chk("rd_w2_stb", {28'h0, s_stb}, 32'h2);
    chk("rd_w2_nonsel_ack", {31'h0, m1_ack}, 32'h0);
    step();
    s_ack = 4'b0010;
    settle();
    chk("rd_c3_stb", {28'h0, s_stb}, 32'h2);
    chk("rd_c3_ack", {31'h0, m1_ack}, 32'h1);
    chk("rd_c3_data", m1_rdat, 32'h1234_5678);
    chk("rd_c3_m0ack", {31'h0, m0_ack}, 32'h0);
    chk("rd_c3_m0data", m0_rdat, 32'h0);
    step();
    clear_in();
    settle();
    chk("rd_idle_after", {27'h0, s_cyc, s_stb}, 32'h0);

    // arbitration after reset: tie goes to m0, then m1, then m0 again
    do_reset();
    req0(32'h0000_0010); req1(32'h0000_0020);
    step();
    s_ack = 4'b0001;
    settle();
    chk("arb1_addr", s_addr, 32'h0000_0010);
    chk("arb1_stb", {28'h0, s_stb}, 32'h1);
    chk("arb1_acks", {30'h0, m0_ack, m1_ack}, 32'h2);
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 4'b0000;
    settle();
    chk("arb1_idle_stb", {28'h0, s_stb}, 32'h0);
    step();
    s_ack = 4'b0001;
    settle();
    chk("arb2_addr", s_addr, 32'h0000_0020);
    chk("arb2_acks", {30'h0, m0_ack, m1_ack}, 32'h1);
    step();
    clear_in();
    req0(32'h0000_0010); req1(32'h0000_0020);
    step();
    settle();
    chk("arb3_addr", s_addr, 32'h0000_0010);
    chk("arb3_stb", {28'h0, s_stb}, 32'h1);
    s_ack = 4'b0001;
    step();
    clear_in();
    settle();

    // unmapped: m0 to 0x8000_0000 acks at once with zero data
    req0(32'h8000_0000);
    s0_dat = 32'hFFFF_0000;
    step();
    settle();
    chk("unm_ack", {31'h0, m0_ack}, 32'h1);
    chk("unm_data", m0_rdat, 32'h0);
    chk("unm_stb", {28'h0, s_stb}, 32'h0);
    step();
    clear_in();
    settle();
    chk("unm_idle_stb", {28'h0, s_stb}, 32'h0);

    // timeout: m1 to slave2, which never acks
    req1(32'h2000_0000);
    for (int i = 1; i <= 4; i++) begin
      step();
      settle();
      chk($sformatf("tmo_wait%0d_stb", i), {28'h0, s_stb}, 32'h4);
      chk($sformatf("tmo_wait%0d_ack", i), {30'h0, m1_ack, tmo}, 32'h0);
    end
    step();
    settle();
    chk("tmo_ack", {31'h0, m1_ack}, 32'h1);
    chk("tmo_data", m1_rdat, 32'h0);
    chk("tmo_pulse", {31'h0, tmo}, 32'h1);
    chk("tmo_stb", {28'h0, s_stb}, 32'h0);
    step();
    clear_in();
    settle();
    chk("tmo_after", {31'h0, tmo}, 32'h0);

    // abort: m0 drops cyc in its second wait cycle while m1 waits
    req0(32'h3000_0000);
    step();
    req1(32'h0000_0004);
    settle();
    chk("abt_w1_stb", {28'h0, s_stb}, 32'h8);
    chk("abt_w1_m1ack", {31'h0, m1_ack}, 32'h0);
    step();
    m0_cyc = 0; m0_stb = 0;
    settle();
    chk("abt_w2_stb", {28'h0, s_stb}, 32'h0);
    chk("abt_w2_ack", {31'h0, m0_ack}, 32'h0);
    step();
    settle();
    chk("abt_idle_stb", {28'h0, s_stb}, 32'h0);
    chk("abt_idle_acks", {30'h0, m0_ack, m1_ack}, 32'h0);
    step();
    s_ack = 4'b0001;
    settle();
    chk("abt_m1_addr", s_addr, 32'h0000_0004);
    chk("abt_m1_stb", {28'h0, s_stb}, 32'h1);
    chk("abt_m1_ack", {31'h0, m1_ack}, 32'h1);
    step();
    clear_in();
    settle();

    // reset during a BUSY1 wait, then a tie grants m0
    req1(32'h1000_0000);
    step();
    settle();
    chk("rstm_busy_stb", {28'h0, s_stb}, 32'h2);
    step();
    rst = 1;
    settle();
    chk("rstm_now_stb", {27'h0, s_cyc, s_stb}, 32'h0);
    step();
    settle();
    chk("rstm_next_out", {26'h0, s_cyc, s_stb, m1_ack}, 32'h0);
    rst = 0;
    req0(32'h0000_0100);
    settle();
    chk("rstm_idle_stb", {28'h0, s_stb}, 32'h0);
    step();
    settle();
    chk("rstm_tie_addr", s_addr, 32'h0000_0100);
    chk("rstm_tie_stb", {28'h0, s_stb}, 32'h1);
    step();
    clear_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
